// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch FSM (IDLE/RUN/HALT) with one-entry output register
// Optional build macro: FETCH_WRAP_EN (wrap PC to 0 after LAST_WORD instead of halting)
module fetch_controller #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          LAST_WORD = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] imem_pc,
    input  logic [15:0] imem_instr,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [3:0]  LAST_IDX      = 4'(LAST_WORD);
    localparam logic [14:0] RESET_WORD_PC = RESET_PC[15:1];

    // PC is kept as a halfword address so bit 0 of the byte address is zero by construction
    state_t      state_q, state_d;
    logic [14:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_instr_q, out_instr_d;
    logic [15:0] out_pc_q, out_pc_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    logic        accept;
    logic        redirect_ok;
    logic        unused_redirect_bit;

    assign unused_redirect_bit = redirect_pc[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_WORD_PC;
            out_valid_q   <= 1'b0;
            out_instr_q   <= 16'h0000;
            out_pc_q      <= 16'h0000;
            fetch_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        fetch_count_d = fetch_count_q;

        accept      = out_valid_q && out_ready;
        redirect_ok = (redirect_pc[15:5] == 11'd0) && (redirect_pc[4:1] <= LAST_IDX);

        // Counting is independent of redirect so a flushed-but-accepted entry still counts
        if (accept && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN, HALT: begin
                if (redirect) begin
                    out_valid_d = 1'b0;
                    pc_d        = redirect_pc[15:1];
                    state_d     = redirect_ok ? RUN : HALT;
                end else begin
                    if (accept) begin
                        out_valid_d = 1'b0;
                    end
                    if ((state_q == RUN) && (!out_valid_q || out_ready)) begin
                        out_valid_d = 1'b1;
                        out_instr_d = imem_instr;
                        out_pc_d    = {pc_q, 1'b0};
                        pc_d        = pc_q + 15'd1;
                        if (pc_q[3:0] == LAST_IDX) begin
`ifdef FETCH_WRAP_EN
                            pc_d = 15'd0;
`else
                            state_d = HALT;
`endif
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_pc     = {pc_q, 1'b0};
    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign halted      = (state_q == HALT);
    assign fetch_count = fetch_count_q;

endmodule
